// File: rtl/rvvi_coverage_monitor.sv
// Passive RVVI trace coverage collector: accumulates opcode/register/mode/interrupt
// bitmaps and event counters from a single-retire trace, plus sticky protocol flags.
module rvvi_coverage_monitor #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             valid,
  input  logic [63:0]      order,
  input  logic [31:0]      insn,
  input  logic             trap,
  input  logic             debug_mode,
  input  logic [XLEN-1:0]  pc_rdata,
  input  logic [1:0]       mode,
  input  logic [3:0]       intr,
  input  logic [31:0]      x_wb,
  input  logic [31:0]      f_wb,
  input  logic [31:0]      v_wb,
  input  logic [2:0]       access,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] trap_cnt,
  output logic [CNT_W-1:0] debug_cnt,
  output logic [31:0]      opcode_hit,
  output logic [2:0]       cq_hit,
  output logic [31:0]      xreg_hit,
  output logic [31:0]      freg_hit,
  output logic [31:0]      vreg_hit,
  output logic [3:0]       mode_hit,
  output logic [3:0]       intr_hit,
  output logic [2:0]       access_hit,
  output logic [XLEN-1:0]  last_pc,
  output logic             order_err,
  output logic             illegal_mode,
  output logic [7:0]       cov_count
);

  // All coverage state in one record so reset and clear wipe it identically.
  typedef struct packed {
    logic             first_seen;
    logic [63:0]      prev_order;
    logic [CNT_W-1:0] retired;
    logic [CNT_W-1:0] traps;
    logic [CNT_W-1:0] debugs;
    logic [31:0]      opc;
    logic [2:0]       cq;
    logic [31:0]      xr;
    logic [31:0]      fr;
    logic [31:0]      vr;
    logic [3:0]       md;
    logic [3:0]       it;
    logic [2:0]       ac;
    logic [XLEN-1:0]  pc;
    logic             oerr;
    logic             ill;
  } cov_state_t;

  localparam int BIN_W = 32 + 3 + 32 + 32 + 32 + 4 + 4 + 3;

  cov_state_t st_q, st_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  always_comb begin
    st_d = st_q;
    if (valid) begin
      st_d.first_seen = 1'b1;
      st_d.prev_order = order;
      st_d.pc         = pc_rdata;
      // 64-bit add wraps naturally, so all-ones followed by zero is in sequence.
      if (st_q.first_seen && (order != st_q.prev_order + 64'd1))
        st_d.oerr = 1'b1;
      if (mode == 2'd2)
        st_d.ill = 1'b1;
      if (debug_mode) begin
        st_d.debugs = sat_inc(st_q.debugs);
      end else begin
        st_d.md[mode] = 1'b1;
        st_d.it       = st_q.it | intr;
        if (trap) begin
          st_d.traps = sat_inc(st_q.traps);
        end else begin
          st_d.retired = sat_inc(st_q.retired);
          if (insn[1:0] == 2'b11)
            st_d.opc[insn[6:2]] = 1'b1;
          else
            st_d.cq[insn[1:0]] = 1'b1;
          // x0 is hardwired zero, so a write to it is never coverage.
          st_d.xr = st_q.xr | {x_wb[31:1], 1'b0};
          st_d.fr = st_q.fr | f_wb;
          st_d.vr = st_q.vr | v_wb;
          st_d.ac = st_q.ac | access;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   st_q <= '0;
    else if (clear) st_q <= '0;
    else            st_q <= st_d;
  end

  assign retired_cnt  = st_q.retired;
  assign trap_cnt     = st_q.traps;
  assign debug_cnt    = st_q.debugs;
  assign opcode_hit   = st_q.opc;
  assign cq_hit       = st_q.cq;
  assign xreg_hit     = st_q.xr;
  assign freg_hit     = st_q.fr;
  assign vreg_hit     = st_q.vr;
  assign mode_hit     = st_q.md;
  assign intr_hit     = st_q.it;
  assign access_hit   = st_q.ac;
  assign last_pc      = st_q.pc;
  assign order_err    = st_q.oerr;
  assign illegal_mode = st_q.ill;

  logic [BIN_W-1:0] all_bins;
  assign all_bins = {st_q.opc, st_q.cq, st_q.xr, st_q.fr, st_q.vr,
                     st_q.md, st_q.it, st_q.ac};

  always_comb begin
    cov_count = 8'd0;
    for (int i = 0; i < BIN_W; i++)
      cov_count = cov_count + {7'd0, all_bins[i]};
  end

endmodule

// File: tb/tb_rvvi_coverage_monitor.sv
// Table-driven scoreboard bench for rvvi_coverage_monitor, plus async-reset and
// counter-saturation sequences on a narrow-counter instance.
module tb_rvvi_coverage_monitor;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic        valid = 1'b0;
  logic [63:0] order = '0;
  logic [31:0] insn = '0;
  logic        trap = 1'b0;
  logic        debug_mode = 1'b0;
  logic [63:0] pc_rdata = '0;
  logic [1:0]  mode = '0;
  logic [3:0]  intr = '0;
  logic [31:0] x_wb = '0, f_wb = '0, v_wb = '0;
  logic [2:0]  access = '0;

  logic [31:0] retired_cnt, trap_cnt, debug_cnt;
  logic [31:0] opcode_hit, xreg_hit, freg_hit, vreg_hit;
  logic [2:0]  cq_hit, access_hit;
  logic [3:0]  mode_hit, intr_hit;
  logic [63:0] last_pc;
  logic        order_err, illegal_mode;
  logic [7:0]  cov_count;

  // narrow-counter instance for saturation
  logic        s_valid = 1'b0;
  logic [63:0] s_order = '0;
  logic [3:0]  s_ret, s_trp, s_dbg;
  logic [31:0] s_opc, s_xr, s_fr, s_vr;
  logic [2:0]  s_cq, s_ac;
  logic [3:0]  s_md, s_it;
  logic [63:0] s_pc;
  logic        s_oe, s_il;
  logic [7:0]  s_cov;

  always #5 clk = ~clk;

  rvvi_coverage_monitor #(.XLEN(64), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .valid(valid), .order(order),
    .insn(insn), .trap(trap), .debug_mode(debug_mode), .pc_rdata(pc_rdata),
    .mode(mode), .intr(intr), .x_wb(x_wb), .f_wb(f_wb), .v_wb(v_wb), .access(access),
    .retired_cnt(retired_cnt), .trap_cnt(trap_cnt), .debug_cnt(debug_cnt),
    .opcode_hit(opcode_hit), .cq_hit(cq_hit), .xreg_hit(xreg_hit),
    .freg_hit(freg_hit), .vreg_hit(vreg_hit), .mode_hit(mode_hit),
    .intr_hit(intr_hit), .access_hit(access_hit), .last_pc(last_pc),
    .order_err(order_err), .illegal_mode(illegal_mode), .cov_count(cov_count)
  );

  rvvi_coverage_monitor #(.XLEN(64), .CNT_W(4)) dut_sat (
    .clk(clk), .reset_n(reset_n), .clear(1'b0), .valid(s_valid), .order(s_order),
    .insn(insn), .trap(trap), .debug_mode(debug_mode), .pc_rdata(pc_rdata),
    .mode(mode), .intr(intr), .x_wb(x_wb), .f_wb(f_wb), .v_wb(v_wb), .access(access),
    .retired_cnt(s_ret), .trap_cnt(s_trp), .debug_cnt(s_dbg),
    .opcode_hit(s_opc), .cq_hit(s_cq), .xreg_hit(s_xr),
    .freg_hit(s_fr), .vreg_hit(s_vr), .mode_hit(s_md),
    .intr_hit(s_it), .access_hit(s_ac), .last_pc(s_pc),
    .order_err(s_oe), .illegal_mode(s_il), .cov_count(s_cov)
  );

  typedef struct {
    logic [31:0] ret, trp, dbg, opc;
    logic [2:0]  cq;
    logic [31:0] xr, fr, vr;
    logic [3:0]  md, it;
    logic [2:0]  ac;
    logic [63:0] pc;
    logic        oe, il;
    logic [7:0]  cov;
  } exp_t;

  typedef struct {
    logic        vld, clr;
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap, dbg;
    logic [63:0] pc;
    logic [1:0]  mode;
    logic [3:0]  intr;
    logic [31:0] xwb, fwb, vwb;
    logic [2:0]  acc;
    exp_t        e;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  vec_t tbl[14];
  exp_t zero_e;

  function automatic exp_t E(input logic [31:0] ret, input logic [31:0] trp,
      input logic [31:0] dbg, input logic [31:0] opc, input logic [2:0] cq,
      input logic [31:0] xr, input logic [31:0] fr, input logic [31:0] vr,
      input logic [3:0] md, input logic [3:0] it, input logic [2:0] ac,
      input logic [63:0] pc, input logic oe, input logic il, input logic [7:0] cov);
    exp_t r;
    r.ret = ret; r.trp = trp; r.dbg = dbg; r.opc = opc; r.cq = cq;
    r.xr = xr; r.fr = fr; r.vr = vr; r.md = md; r.it = it; r.ac = ac;
    r.pc = pc; r.oe = oe; r.il = il; r.cov = cov;
    return r;
  endfunction

  function automatic vec_t V(input logic vld, input logic clr, input logic [63:0] ord,
      input logic [31:0] ins, input logic trp, input logic dbg, input logic [63:0] pc,
      input logic [1:0] md, input logic [3:0] it, input logic [31:0] xw,
      input logic [31:0] fw, input logic [31:0] vw, input logic [2:0] ac, input exp_t e);
    vec_t r;
    r.vld = vld; r.clr = clr; r.order = ord; r.insn = ins; r.trap = trp; r.dbg = dbg;
    r.pc = pc; r.mode = md; r.intr = it; r.xwb = xw; r.fwb = fw; r.vwb = vw;
    r.acc = ac; r.e = e;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cmp(input exp_t e, input string tg);
    chk({tg, ".retired_cnt"}, 64'(retired_cnt), 64'(e.ret));
    chk({tg, ".trap_cnt"},    64'(trap_cnt),    64'(e.trp));
    chk({tg, ".debug_cnt"},   64'(debug_cnt),   64'(e.dbg));
    chk({tg, ".opcode_hit"},  64'(opcode_hit),  64'(e.opc));
    chk({tg, ".cq_hit"},      64'(cq_hit),      64'(e.cq));
    chk({tg, ".xreg_hit"},    64'(xreg_hit),    64'(e.xr));
    chk({tg, ".freg_hit"},    64'(freg_hit),    64'(e.fr));
    chk({tg, ".vreg_hit"},    64'(vreg_hit),    64'(e.vr));
    chk({tg, ".mode_hit"},    64'(mode_hit),    64'(e.md));
    chk({tg, ".intr_hit"},    64'(intr_hit),    64'(e.it));
    chk({tg, ".access_hit"},  64'(access_hit),  64'(e.ac));
    chk({tg, ".last_pc"},     last_pc,          e.pc);
    chk({tg, ".order_err"},   64'(order_err),   64'(e.oe));
    chk({tg, ".illegal_mode"},64'(illegal_mode),64'(e.il));
    chk({tg, ".cov_count"},   64'(cov_count),   64'(e.cov));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t  e;
    logic [63:0] ones;
    ones   = '1;
    zero_e = E(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);

    tbl[0]  = V(1,0,5,   32'h13,  0,0,64'h1000,3,4'h0,32'h2,0,0,3'b000,
                E(1,0,0,32'h10,  3'b000,2,0,0,4'b1000,4'h0,0,64'h1000,0,0,3));
    tbl[1]  = V(1,0,6,   32'h33,  0,0,64'h1004,3,4'h0,32'h2,0,0,3'b000,
                E(2,0,0,32'h1010,3'b000,2,0,0,4'b1000,4'h0,0,64'h1004,0,0,4));
    tbl[2]  = V(1,0,7,   32'h4501,0,0,64'h1008,3,4'h0,0,0,0,3'b000,
                E(3,0,0,32'h1010,3'b010,2,0,0,4'b1000,4'h0,0,64'h1008,0,0,5));
    tbl[3]  = V(1,0,8,   32'h73,  1,0,64'h2000,0,4'b0010,32'hFFFF_FFFF,32'hFF,32'hFF,3'b111,
                E(3,1,0,32'h1010,3'b010,2,0,0,4'b1001,4'b0010,0,64'h2000,0,0,7));
    tbl[4]  = V(1,0,9,   32'h6F,  0,1,64'h3000,3,4'hF,32'hF0,32'hF0,32'hF0,3'b111,
                E(3,1,1,32'h1010,3'b010,2,0,0,4'b1001,4'b0010,0,64'h3000,0,0,7));
    tbl[5]  = V(1,0,10,  32'h03,  0,0,64'h4000,2,4'b1000,32'h1,32'h8000_0001,32'h4,3'b101,
                E(4,1,1,32'h1011,3'b010,2,32'h8000_0001,4,4'b1101,4'b1010,3'b101,64'h4000,0,1,15));
    tbl[6]  = V(1,0,12,  32'h4502,0,0,64'h5000,3,4'h0,0,0,0,3'b000,
                E(5,1,1,32'h1011,3'b110,2,32'h8000_0001,4,4'b1101,4'b1010,3'b101,64'h5000,1,1,16));
    tbl[7]  = V(1,0,13,  32'h13,  0,0,64'h5004,3,4'h0,0,0,0,3'b000,
                E(6,1,1,32'h1011,3'b110,2,32'h8000_0001,4,4'b1101,4'b1010,3'b101,64'h5004,1,1,16));
    tbl[8]  = V(1,1,100, 32'h13,  0,0,64'h6000,3,4'hF,32'h4,0,0,3'b111, zero_e);
    tbl[9]  = V(1,0,ones,32'h13,  0,0,64'h10,0,4'h0,0,0,0,3'b010,
                E(1,0,0,32'h10,3'b000,0,0,0,4'b0001,4'h0,3'b010,64'h10,0,0,3));
    tbl[10] = V(1,0,0,   32'h13,  0,0,64'h14,0,4'h0,0,0,0,3'b000,
                E(2,0,0,32'h10,3'b000,0,0,0,4'b0001,4'h0,3'b010,64'h14,0,0,3));
    tbl[11] = V(0,0,55,  32'h73,  0,0,64'h99,2,4'hF,32'hFF,32'hFF,32'hFF,3'b111,
                E(2,0,0,32'h10,3'b000,0,0,0,4'b0001,4'h0,3'b010,64'h14,0,0,3));
    tbl[12] = V(1,0,1,   32'h73,  0,1,64'h20,0,4'h0,32'hFF,0,0,3'b000,
                E(2,0,1,32'h10,3'b000,0,0,0,4'b0001,4'h0,3'b010,64'h20,0,0,3));
    tbl[13] = V(1,0,5,   32'h73,  0,1,64'h24,0,4'h0,0,0,0,3'b000,
                E(2,0,2,32'h10,3'b000,0,0,0,4'b0001,4'h0,3'b010,64'h24,1,0,3));

    // reset state
    #3;
    cmp(zero_e, "reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // back-to-back records; expected pushed on drive, popped after the edge
    foreach (tbl[i]) begin
      valid = tbl[i].vld; clear = tbl[i].clr; order = tbl[i].order;
      insn = tbl[i].insn; trap = tbl[i].trap; debug_mode = tbl[i].dbg;
      pc_rdata = tbl[i].pc; mode = tbl[i].mode; intr = tbl[i].intr;
      x_wb = tbl[i].xwb; f_wb = tbl[i].fwb; v_wb = tbl[i].vwb; access = tbl[i].acc;
      sb.push_back(tbl[i].e);
      @(negedge clk);
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
        e = sb.pop_front();
        cmp(e, $sformatf("vec%0d", i));
      end
    end
    valid = 1'b0; clear = 1'b0; trap = 1'b0; debug_mode = 1'b0;

    // asynchronous reset mid-stream: outputs must drop before the next edge
    #2 reset_n = 1'b0;
    #1 cmp(zero_e, "async_rst");
    @(negedge clk);
    reset_n = 1'b1;

    // narrow counter saturates at 4'hF and never wraps
    insn = 32'h13; mode = 2'd3; intr = '0; x_wb = '0; f_wb = '0; v_wb = '0; access = '0;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1;
      s_order = 64'(i);
      @(negedge clk);
      chk($sformatf("sat%0d.retired_cnt", i), 64'(s_ret), (i + 1 > 15) ? 64'hF : 64'(i + 1));
    end
    s_valid = 1'b0;
    @(negedge clk);
    chk("sat_final.retired_cnt", 64'(s_ret), 64'hF);
    chk("sat_final.order_err", 64'(s_oe), 64'h0);
    chk("sat_final.trap_cnt", 64'(s_trp), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
